// File: rtl/psram_access_arbiter_pkg.sv
// Shared types and helpers for the PSRAM access arbiter: FSM state
// encoding, command codes and the burst-length helper.
package psram_access_arbiter_pkg;

  // 8-bit state encoding, matching the other PSRAM FSM packages.
  typedef logic [7:0] t_arb_state;

  localparam t_arb_state ST_IDLE     = 8'h00;
  localparam t_arb_state ST_GRANT_WR = 8'h01;
  localparam t_arb_state ST_GRANT_RD = 8'h02;
  localparam t_arb_state ST_BURST_WR = 8'h03;
  localparam t_arb_state ST_BURST_RD = 8'h04;
  localparam t_arb_state ST_RELEASE  = 8'h05;

  // Value driven on mem_cmd for each direction.
  localparam logic ARB_WR = 1'b1;
  localparam logic ARB_RD = 1'b0;

  // Number of controller clocks a burst of burst_bytes occupies.
  // The controller moves 8 bytes per clock; never report less than one.
  function automatic int unsigned burst_cycles(input int unsigned burst_bytes);
    if (burst_bytes < 8) begin
      return 1;
    end
    return burst_bytes / 8;
  endfunction

endpackage

// File: rtl/psram_access_arbiter_priority.sv
// Grant decision between the write and read requesters plus the
// consecutive-write streak counter that prevents read starvation.
// With PSRAM_ARB_STATS_EN defined, also flags reads forced by the limit.
module psram_arb_priority
  import psram_access_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WR_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en_i,
  input  logic wr_rq_i,
  input  logic rd_rq_i,
  output logic grant_wr_o,
  output logic grant_rd_o
`ifdef PSRAM_ARB_STATS_EN
  ,
  output logic starve_o
`endif
);

  localparam logic [2:0] STREAK_LIMIT = 3'(MAX_WR_STREAK);
  localparam logic [2:0] STREAK_SAT   = 3'd7;

  logic [2:0] streak_q;
  logic [2:0] streak_d;

  // Write wins unless a read is waiting and the write streak is used up.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_wr_o = 1'b0;
    grant_rd_o = 1'b0;
    streak_d   = streak_q;
    if (arb_en_i) begin
      grant_wr_o = wr_rq_i && (!rd_rq_i || (streak_q < STREAK_LIMIT));
      grant_rd_o = rd_rq_i && !grant_wr_o;
    end
    if (grant_wr_o) begin
      // The streak only grows while a read is actually being held off.
      if (rd_rq_i) begin
        streak_d = (streak_q == STREAK_SAT) ? streak_q : streak_q + 3'd1;
      end else begin
        streak_d = 3'd0;
      end
    end else if (grant_rd_o) begin
      streak_d = 3'd0;
    end
  end

`ifdef PSRAM_ARB_STATS_EN
  // A read granted while a write was also asking was forced by the limit.
  assign starve_o = grant_rd_o && wr_rq_i;
`endif

  // Streak counter register.
  // NOTE: sequential state is written with non-blocking assignments so all
  // flops sample their inputs from the same edge regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      streak_q <= 3'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/psram_access_arbiter.sv
// Arbiter sharing the PSRAM controller command port between the camera
// write path and the LCD read path. Grants one requester, forwards its
// command, tracks the burst and releases the port with a one-cycle bubble.
// Optional statistics counters are built when PSRAM_ARB_STATS_EN is defined.
module psram_access_arbiter
  import psram_access_arbiter_pkg::*;
#(
  parameter int unsigned MEMORY_BURST  = 32,
  parameter int unsigned MAX_WR_STREAK = 4,
  parameter int unsigned ADDR_WIDTH    = 21
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_calib,
  input  logic                  wr_rq,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_cmd_en,
  output logic                  wr_ack,
  input  logic                  rd_rq,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_cmd_en,
  output logic                  rd_ack,
  input  logic                  rd_data_valid,
  output logic                  mem_cmd,
  output logic                  mem_cmd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  busy
`ifdef PSRAM_ARB_STATS_EN
  ,
  output logic [15:0]           stat_wr_bursts,
  output logic [15:0]           stat_rd_bursts,
  output logic [7:0]            stat_starve_events,
  output logic                  stat_proto_err
`endif
);

  localparam int unsigned BURST_CYCLES = burst_cycles(MEMORY_BURST);
  localparam logic [7:0]  BURST_LAST   = 8'(BURST_CYCLES - 1);

  t_arb_state            state_q, state_d;
  logic                  owner_wr_q, owner_wr_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic                  bubble_q, bubble_d;
  logic                  mem_cmd_en_q, mem_cmd_en_d;
  logic                  mem_cmd_q, mem_cmd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic arb_en;
  logic grant_wr;
  logic grant_rd;

  // New grants only from a settled IDLE with the controller calibrated.
  assign arb_en = (state_q == ST_IDLE) && mem_calib && !bubble_q;

`ifdef PSRAM_ARB_STATS_EN
  logic starve;
`endif

  psram_arb_priority #(
    .MAX_WR_STREAK(MAX_WR_STREAK)
  ) u_priority (
    .clk        (clk),
    .reset_n    (reset_n),
    .arb_en_i   (arb_en),
    .wr_rq_i    (wr_rq),
    .rd_rq_i    (rd_rq),
    .grant_wr_o (grant_wr),
    .grant_rd_o (grant_rd)
`ifdef PSRAM_ARB_STATS_EN
    ,
    .starve_o   (starve)
`endif
  );

  // Next-state logic: grant, command issue, burst tracking and release.
  always_comb begin
    state_d      = state_q;
    owner_wr_d   = owner_wr_q;
    burst_cnt_d  = burst_cnt_q;
    bubble_d     = 1'b0;
    mem_cmd_en_d = 1'b0;
    mem_cmd_d    = mem_cmd_q;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          state_d    = ST_GRANT_WR;
          owner_wr_d = 1'b1;
        end else if (grant_rd) begin
          state_d    = ST_GRANT_RD;
          owner_wr_d = 1'b0;
        end
      end

      ST_GRANT_WR: begin
        if (wr_cmd_en) begin
          mem_addr_d   = wr_addr;
          mem_cmd_d    = ARB_WR;
          mem_cmd_en_d = 1'b1;
          burst_cnt_d  = 8'd0;
          state_d      = ST_BURST_WR;
        end else if (!wr_rq) begin
          state_d = ST_RELEASE;
        end
      end

      ST_GRANT_RD: begin
        if (rd_cmd_en) begin
          mem_addr_d   = rd_addr;
          mem_cmd_d    = ARB_RD;
          mem_cmd_en_d = 1'b1;
          burst_cnt_d  = 8'd0;
          state_d      = ST_BURST_RD;
        end else if (!rd_rq) begin
          state_d = ST_RELEASE;
        end
      end

      // Writes are timed: the burst occupies BURST_CYCLES clocks starting
      // with the mem_cmd_en cycle.
      ST_BURST_WR: begin
        if (burst_cnt_q == BURST_LAST) begin
          burst_cnt_d = 8'd0;
          state_d     = ST_RELEASE;
        end else begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end

      // Reads finish when the controller has returned every beat.
      ST_BURST_RD: begin
        if (rd_data_valid) begin
          if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = 8'd0;
            state_d     = ST_RELEASE;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end

      // Keep the ack up until the owner lets go, then idle for one cycle so
      // the next requester never sees a stale ack.
      ST_RELEASE: begin
        if (owner_wr_q ? !wr_rq : !rd_rq) begin
          state_d  = ST_IDLE;
          bubble_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and command registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_wr_q   <= 1'b0;
      burst_cnt_q  <= 8'd0;
      bubble_q     <= 1'b0;
      mem_cmd_en_q <= 1'b0;
      mem_cmd_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_wr_q   <= owner_wr_d;
      burst_cnt_q  <= burst_cnt_d;
      bubble_q     <= bubble_d;
      mem_cmd_en_q <= mem_cmd_en_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign wr_ack     = busy && owner_wr_q;
  assign rd_ack     = busy && !owner_wr_q;
  assign mem_cmd_en = mem_cmd_en_q;
  assign mem_cmd    = mem_cmd_q;
  assign mem_addr   = mem_addr_q;

`ifdef PSRAM_ARB_STATS_EN
  logic        wr_issue;
  logic        rd_issue;
  logic        dup_cmd;
  logic [15:0] stat_wr_bursts_q;
  logic [15:0] stat_rd_bursts_q;
  logic [7:0]  stat_starve_q;
  logic        stat_proto_err_q;

  assign wr_issue = (state_q == ST_GRANT_WR) && wr_cmd_en;
  assign rd_issue = (state_q == ST_GRANT_RD) && rd_cmd_en;
  // A command pulse from the owner once its command is already out.
  assign dup_cmd  = ((state_q == ST_BURST_WR) && wr_cmd_en) ||
                    ((state_q == ST_BURST_RD) && rd_cmd_en) ||
                    ((state_q == ST_RELEASE) && (owner_wr_q ? wr_cmd_en : rd_cmd_en));

  // Statistics counters; the burst and starve counters wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_wr_bursts_q <= 16'd0;
      stat_rd_bursts_q <= 16'd0;
      stat_starve_q    <= 8'd0;
      stat_proto_err_q <= 1'b0;
    end else begin
      if (wr_issue) stat_wr_bursts_q <= stat_wr_bursts_q + 16'd1;
      if (rd_issue) stat_rd_bursts_q <= stat_rd_bursts_q + 16'd1;
      if (starve)   stat_starve_q    <= stat_starve_q + 8'd1;
      if (dup_cmd)  stat_proto_err_q <= 1'b1;
    end
  end

  assign stat_wr_bursts     = stat_wr_bursts_q;
  assign stat_rd_bursts     = stat_rd_bursts_q;
  assign stat_starve_events = stat_starve_q;
  assign stat_proto_err     = stat_proto_err_q;
`endif

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Directed bench for psram_access_arbiter: grant latency, priority and
// streak limit, abort, duplicate command, calibration gate, reset mid-burst.
module tb_psram_access_arbiter;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_calib = 1'b0;
  logic          wr_rq = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_cmd_en = 1'b0;
  logic          wr_ack;
  logic          rd_rq = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_cmd_en = 1'b0;
  logic          rd_ack;
  logic          rd_data_valid = 1'b0;
  logic          mem_cmd;
  logic          mem_cmd_en;
  logic [AW-1:0] mem_addr;
  logic          busy;
`ifdef PSRAM_ARB_STATS_EN
  logic [15:0]   stat_wr_bursts;
  logic [15:0]   stat_rd_bursts;
  logic [7:0]    stat_starve_events;
  logic          stat_proto_err;
`endif

  int total = 0;
  int bad = 0;
  int cmd_pulses = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  psram_access_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_calib     (mem_calib),
    .wr_rq         (wr_rq),
    .wr_addr       (wr_addr),
    .wr_cmd_en     (wr_cmd_en),
    .wr_ack        (wr_ack),
    .rd_rq         (rd_rq),
    .rd_addr       (rd_addr),
    .rd_cmd_en     (rd_cmd_en),
    .rd_ack        (rd_ack),
    .rd_data_valid (rd_data_valid),
    .mem_cmd       (mem_cmd),
    .mem_cmd_en    (mem_cmd_en),
    .mem_addr      (mem_addr),
    .busy          (busy)
`ifdef PSRAM_ARB_STATS_EN
    ,
    .stat_wr_bursts     (stat_wr_bursts),
    .stat_rd_bursts     (stat_rd_bursts),
    .stat_starve_events (stat_starve_events),
    .stat_proto_err     (stat_proto_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Mid-cycle monitor: acks are mutually exclusive; count command strobes.
  always @(negedge clk) begin
    if (run) begin
      check("ack_mutex", 32'(wr_ack & rd_ack), 32'd0);
      if (mem_cmd_en) cmd_pulses++;
    end
  end

  // Bounded wait for either ack; reports which requester won.
  task automatic wait_grant(output bit is_wr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_ack || rd_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
    is_wr = wr_ack;
  endtask

  // Complete an already-granted write: command, 4-cycle burst, release.
  task automatic wr_burst(input logic [AW-1:0] addr);
    wr_addr   = addr;
    wr_cmd_en = 1'b1;
    step();
    wr_cmd_en = 1'b0;
    check("wr_cmd_en", 32'(mem_cmd_en), 32'd1);
    check("wr_cmd", 32'(mem_cmd), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'(addr));
    step();
    check("wr_cmd_en_len", 32'(mem_cmd_en), 32'd0);
    step_n(3);
    check("wr_ack_hold", 32'(wr_ack), 32'd1);
    wr_rq = 1'b0;
    step();
    check("wr_ack_drop", 32'(wr_ack), 32'd0);
    check("wr_busy_drop", 32'(busy), 32'd0);
  endtask

  // Complete an already-granted read: command, 4 strobes, release.
  task automatic rd_burst(input logic [AW-1:0] addr);
    rd_addr   = addr;
    rd_cmd_en = 1'b1;
    step();
    rd_cmd_en = 1'b0;
    check("rd_cmd_en", 32'(mem_cmd_en), 32'd1);
    check("rd_cmd", 32'(mem_cmd), 32'd0);
    check("rd_addr", 32'(mem_addr), 32'(addr));
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1'b1;
      step();
      if (i == 0) check("rd_cmd_en_len", 32'(mem_cmd_en), 32'd0);
    end
    rd_data_valid = 1'b0;
    check("rd_ack_hold", 32'(rd_ack), 32'd1);
    rd_rq = 1'b0;
    step();
    check("rd_ack_drop", 32'(rd_ack), 32'd0);
    check("rd_busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         is_wr;
    logic [5:0] seq;
    int         p0;

    // Reset
    step_n(2);
    reset_n = 1'b1;
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_rd_ack", 32'(rd_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_en", 32'(mem_cmd_en), 32'd0);
    check("rst_cmd", 32'(mem_cmd), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    run = 1'b1;

    // No grant before calibration
    rd_rq = 1'b1;
    step_n(3);
    check("calib_block_ack", 32'(rd_ack), 32'd0);
    check("calib_block_busy", 32'(busy), 32'd0);
    rd_rq     = 1'b0;
    mem_calib = 1'b1;
    step();

    // Single read: ack at t0+1, command at t0+3
    rd_rq = 1'b1;
    step();
    check("t1_rd_ack", 32'(rd_ack), 32'd1);
    check("t1_wr_ack", 32'(wr_ack), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    check("t1_no_cmd_yet", 32'(mem_cmd_en), 32'd0);
    rd_burst(21'h00100);

    // Simultaneous requests: write first, read after the bubble
    step();
    wr_rq = 1'b1;
    rd_rq = 1'b1;
    step();
    check("t2_wr_first", 32'(wr_ack), 32'd1);
    check("t2_rd_wait", 32'(rd_ack), 32'd0);
    wr_burst(21'h01000);
    step();
    check("t2_bubble", 32'(rd_ack), 32'd0);
    step();
    check("t2_rd_grant", 32'(rd_ack), 32'd1);
    rd_burst(21'h02000);

    // Write flood with a read pending: W W W W R W
    wr_rq = 1'b1;
    rd_rq = 1'b1;
    seq   = '0;
    for (int g = 0; g < 6; g++) begin
      wait_grant(is_wr);
      seq[g] = is_wr;
      if (is_wr) begin
        wr_burst(21'(32'h04000 + g));
        if (g < 5) wr_rq = 1'b1;
      end else begin
        rd_burst(21'h08000);
      end
    end
    check("t3_grant_seq", 32'(seq), 32'h2F);
`ifdef PSRAM_ARB_STATS_EN
    check("t3_starve", 32'(stat_starve_events), 32'd1);
    check("t3_wr_bursts", 32'(stat_wr_bursts), 32'd6);
    check("t3_rd_bursts", 32'(stat_rd_bursts), 32'd3);
    check("t3_proto_clean", 32'(stat_proto_err), 32'd0);
`endif

    // Abort: write granted, dropped before its command
    step();
    wr_rq = 1'b1;
    step();
    check("t4_wr_ack", 32'(wr_ack), 32'd1);
    p0    = cmd_pulses;
    wr_rq = 1'b0;
    step();
    check("t4_no_cmd", 32'(mem_cmd_en), 32'd0);
    step();
    check("t4_ack_clear", 32'(wr_ack), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_pulses", 32'(cmd_pulses), 32'(p0));

    // Duplicate command pulse; rd_rq dropped early to expose the strobe count
    step();
    rd_rq = 1'b1;
    step();
    check("t5_rd_ack", 32'(rd_ack), 32'd1);
    p0        = cmd_pulses;
    rd_addr   = 21'h03333;
    rd_cmd_en = 1'b1;
    step();
    rd_cmd_en = 1'b0;
    rd_rq     = 1'b0;
    check("t5_cmd", 32'(mem_cmd_en), 32'd1);
    step();
    rd_cmd_en = 1'b1;
    step();
    rd_cmd_en = 1'b0;
    check("t5_dup_ignored", 32'(mem_cmd_en), 32'd0);
    rd_data_valid = 1'b1;
    step_n(3);
    rd_data_valid = 1'b0;
    step();
    check("t5_three_strobes", 32'(rd_ack), 32'd1);
    rd_data_valid = 1'b1;
    step();
    rd_data_valid = 1'b0;
    check("t5_release_ack", 32'(rd_ack), 32'd1);
    step();
    check("t5_ack_clear", 32'(rd_ack), 32'd0);
    check("t5_pulses", 32'(cmd_pulses), 32'(p0 + 1));
`ifdef PSRAM_ARB_STATS_EN
    check("t5_proto_err", 32'(stat_proto_err), 32'd1);
    check("t5_rd_bursts", 32'(stat_rd_bursts), 32'd4);
`endif

    // Reset in the middle of a read burst
    step();
    rd_rq = 1'b1;
    step();
    check("t6_rd_ack", 32'(rd_ack), 32'd1);
    rd_addr   = 21'h1ABCD;
    rd_cmd_en = 1'b1;
    step();
    rd_cmd_en = 1'b0;
    check("t6_addr", 32'(mem_addr), 32'h1ABCD);
    rd_data_valid = 1'b1;
    step_n(2);
    rd_data_valid = 1'b0;
    check("t6_mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    rd_rq   = 1'b0;
    step();
    reset_n = 1'b1;
    check("t6_rst_rd_ack", 32'(rd_ack), 32'd0);
    check("t6_rst_wr_ack", 32'(wr_ack), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_cmd_en", 32'(mem_cmd_en), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
`ifdef PSRAM_ARB_STATS_EN
    check("t6_rst_stat_rd", 32'(stat_rd_bursts), 32'd0);
    check("t6_rst_stat_err", 32'(stat_proto_err), 32'd0);
    check("t6_rst_stat_starve", 32'(stat_starve_events), 32'd0);
`endif
    p0 = cmd_pulses;
    step_n(3);
    check("t6_no_more_cmd", 32'(cmd_pulses), 32'(p0));
    rd_rq = 1'b1;
    step();
    check("t6_regrant", 32'(rd_ack), 32'd1);
    rd_burst(21'h00042);
`ifdef PSRAM_ARB_STATS_EN
    check("t6_stat_rd", 32'(stat_rd_bursts), 32'd1);
`endif

    step_n(2);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
